// File: rtl/meas_div_sched.sv
// Shared radix-2 restoring divider with a three-way request scheduler.
// Define MEAS_SCHED_RR_EN for round-robin arbitration; fixed priority otherwise.
module meas_div_sched #(
  parameter int DW   = 32,
  parameter int NREQ = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] dividend,
  input  logic [NREQ*DW-1:0] divisor,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic [NREQ-1:0]   done,
  output logic [1:0]        done_id,
  output logic [DW-1:0]     quotient,
  output logic [DW-1:0]     remainder,
  output logic              dz
);

  // state  | meaning
  // S_IDLE | waiting for a request; divide-by-zero resolved here in one cycle
  // S_DIV  | DW restoring steps in progress for requester win_q
  typedef enum logic {S_IDLE, S_DIV} state_t;

  localparam int CW = $clog2(DW) + 1;

  state_t          state_q, state_d;
  logic [1:0]      win_q, win_d;
  logic [DW-1:0]   dvd_q, dvd_d;
  logic [DW-1:0]   dvs_q, dvs_d;
  logic [DW-1:0]   part_q, part_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic [1:0]      done_id_q, done_id_d;
  logic [DW-1:0]   quot_q, quot_d, rem_q, rem_d;
  logic            dz_q, dz_d;

  logic            any_req;
  logic [1:0]      win;
  logic [DW-1:0]   sel_dvd, sel_dvs;
  logic [DW:0]     part_sh, diff;
  logic            ge;
  logic [DW-1:0]   part_nx, quot_nx;

`ifdef MEAS_SCHED_RR_EN
  logic [1:0] ptr_q, ptr_d;
  logic [2:0] rr_sum;

  // Walk offsets high to low so the smallest offset from the pointer wins.
  always_comb begin
    any_req = 1'b0;
    win     = 2'd0;
    rr_sum  = 3'd0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      rr_sum = {1'b0, ptr_q} + 3'(j);
      if (rr_sum >= 3'd3) rr_sum = rr_sum - 3'd3;
      if (req[rr_sum[1:0]]) begin
        any_req = 1'b1;
        win     = rr_sum[1:0];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == S_IDLE && any_req) ptr_d = (win == 2'd2) ? 2'd0 : win + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 2'd0;
    else        ptr_q <= ptr_d;
  end
`else
  always_comb begin
    any_req = 1'b0;
    win     = 2'd0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req[j]) begin
        any_req = 1'b1;
        win     = 2'(j);
      end
    end
  end
`endif

  assign sel_dvd = dividend[int'(win)*DW +: DW];
  assign sel_dvs = divisor[int'(win)*DW +: DW];

  // diff[DW] is the borrow: the difference always fits in DW+1 signed bits.
  assign part_sh = {part_q, dvd_q[DW-1]};
  assign diff    = part_sh - {1'b0, dvs_q};
  assign ge      = ~diff[DW];
  assign part_nx = ge ? diff[DW-1:0] : part_sh[DW-1:0];
  assign quot_nx = {dvd_q[DW-2:0], ge};

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    part_d    = part_q;
    cnt_d     = cnt_q;
    gnt_d     = '0;
    done_d    = '0;
    done_id_d = done_id_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dz_d      = dz_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          gnt_d[win] = 1'b1;
          win_d      = win;
          if (sel_dvs == '0) begin
            quot_d       = '1;
            rem_d        = sel_dvd;
            dz_d         = 1'b1;
            done_d[win]  = 1'b1;
            done_id_d    = win;
          end else begin
            dvd_d   = sel_dvd;
            dvs_d   = sel_dvs;
            part_d  = '0;
            cnt_d   = '0;
            state_d = S_DIV;
          end
        end
      end
      S_DIV: begin
        dvd_d  = quot_nx;
        part_d = part_nx;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(DW - 1)) begin
          quot_d        = quot_nx;
          rem_d         = part_nx;
          dz_d          = 1'b0;
          done_d[win_q] = 1'b1;
          done_id_d     = win_q;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      win_q     <= 2'd0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      part_q    <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      done_id_q <= 2'd0;
      quot_q    <= '0;
      rem_q     <= '0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      part_q    <= part_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      dz_q      <= dz_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign done_id   = done_id_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign dz        = dz_q;
  assign busy      = (state_q == S_DIV);

endmodule

// File: tb/tb_meas_div_sched.sv
// Directed bench for meas_div_sched: vector table plus contention, late-arrival and reset sequences.
module tb_meas_div_sched;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    req;
  logic [3*DW-1:0] dividend, divisor;
  logic [2:0]    gnt, done;
  logic          busy, dz;
  logic [1:0]    done_id;
  logic [DW-1:0] quotient, remainder;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  meas_div_sched #(.DW(DW), .NREQ(3)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .dividend(dividend), .divisor(divisor),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
    .quotient(quotient), .remainder(remainder), .dz(dz)
  );

  typedef struct {
    logic [1:0]  id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic run_op(input logic [1:0] id, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input logic [31:0] r, input logic dzx);
    int n;
    logic [2:0] oh;
    oh = 3'b001 << id;
    dividend[int'(id)*DW +: DW] = a;
    divisor[int'(id)*DW +: DW]  = b;
    req[id] = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (gnt == 3'b000 && n < 5);
    chk("gnt", gnt, oh);
    req[id] = 1'b0;
    if (dzx) begin
      chk("dz_done_with_gnt", done, oh);
      chk("dz_busy", busy, 0);
    end else begin
      chk("busy_after_gnt", busy, 1);
      n = 0;
      while (done == 3'b000 && n < 40) begin
        step();
        n++;
      end
      chk("latency", n, 32);
      chk("done", done, oh);
    end
    chk("done_id", done_id, id);
    chk("quotient", quotient, q);
    chk("remainder", remainder, r);
    chk("dz", dz, dzx);
    step();
    chk("done_pulse", done, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    logic [2:0] gseen[4];
    int         gcyc[4];
    logic [2:0] gexp[4];
    int         ng, got, cyc, n;
    logic       flag;

    vt[0] = '{2'd0, 32'd50_000_000, 32'd1000, 32'd50000, 32'd0, 1'b0};
    vt[1] = '{2'd1, 32'd20_475_000, 32'd4096, 32'd4998, 32'd3192, 1'b0};
    vt[2] = '{2'd2, 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1};
    vt[3] = '{2'd0, 32'd7, 32'd9, 32'd0, 32'd7, 1'b0};
    vt[4] = '{2'd1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0};
    vt[5] = '{2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0};
    vt[6] = '{2'd0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
    vt[7] = '{2'd1, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1};
    vt[8] = '{2'd2, 32'h8000_0000, 32'd3, 32'd715_827_882, 32'd2, 1'b0};

    rst_n = 1'b0;
    req = 3'b000;
    dividend = '0;
    divisor = '0;
    step();
    step();
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_quot", quotient, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_dz", dz, 0);
    chk("rst_id", done_id, 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 9; i++)
      run_op(vt[i].id, vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].dz);

    // Contention with all three requests held high.
    do_reset();
`ifdef MEAS_SCHED_RR_EN
    ng = 4;
    gexp[0] = 3'b001; gexp[1] = 3'b010; gexp[2] = 3'b100; gexp[3] = 3'b001;
`else
    ng = 3;
    gexp[0] = 3'b001; gexp[1] = 3'b001; gexp[2] = 3'b001; gexp[3] = 3'b001;
`endif
    for (int i = 0; i < 3; i++) begin
      dividend[i*DW +: DW] = 32'd1000;
      divisor[i*DW +: DW]  = 32'd10;
    end
    req = 3'b111;
    got = 0;
    cyc = 0;
    while (got < ng && cyc < 200) begin
      step();
      cyc++;
      if (gnt != 3'b000) begin
        gseen[got] = gnt;
        gcyc[got]  = cyc;
        got++;
      end
    end
    req = 3'b000;
    chk("cont_count", got, ng);
    for (int i = 0; i < ng; i++) begin
      if (i < got) begin
        chk("cont_order", gseen[i], gexp[i]);
        if (i > 0) chk("cont_spacing", gcyc[i] - gcyc[i-1], 33);
      end
    end

    // Late arrival: second request must wait for the first done.
    do_reset();
    dividend[0*DW +: DW] = 32'd1000; divisor[0*DW +: DW] = 32'd10;
    dividend[1*DW +: DW] = 32'd500;  divisor[1*DW +: DW] = 32'd5;
    req[0] = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (gnt == 3'b000 && n < 5);
    chk("late_gnt0", gnt, 3'b001);
    req[0] = 1'b0;
    repeat (5) step();
    req[1] = 1'b1;
    flag = 1'b0;
    n = 0;
    while (done == 3'b000 && n < 40) begin
      step();
      n++;
      if (gnt != 3'b000) flag = 1'b1;
    end
    chk("late_done0", done, 3'b001);
    chk("late_no_early_gnt", flag, 0);
    step();
    chk("late_gnt1", gnt, 3'b010);
    req[1] = 1'b0;
    n = 0;
    while (done == 3'b000 && n < 40) begin
      step();
      n++;
    end
    chk("late_done1", done, 3'b010);
    chk("late_quot1", quotient, 100);

    // Reset ten cycles into a division.
    dividend[0*DW +: DW] = 32'd100; divisor[0*DW +: DW] = 32'd7;
    req[0] = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (gnt == 3'b000 && n < 5);
    chk("mid_gnt", gnt, 3'b001);
    req[0] = 1'b0;
    repeat (10) step();
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_quot", quotient, 0);
    chk("mid_rst_rem", remainder, 0);
    chk("mid_rst_id", done_id, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_gnt", gnt, 0);
    step();
    step();
    rst_n = 1'b1;
    flag = 1'b0;
    repeat (40) begin
      step();
      if (done != 3'b000 || busy) flag = 1'b1;
    end
    chk("mid_no_done", flag, 0);
    run_op(2'd0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
